// File: rtl/gray_sobel_pkg.sv
// Shared types for the gray-scale Sobel path: pixel width, window size,
// window-buffer FSM states and the packed 3x3 window type.
package gray_sobel_pkg;

  localparam int unsigned MAX_PIXEL_BITS = 8;
  localparam int unsigned WIN_PIXELS     = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } win_state_e;

  // Slot k at [k*MAX_PIXEL_BITS +: MAX_PIXEL_BITS], k=0 top-left, k=8 bottom-right.
  typedef logic [WIN_PIXELS-1:0][MAX_PIXEL_BITS-1:0] win_pixels_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Two IMG_WIDTH-deep line stores: line A holds the previous line, line B the
// one before it. Reads are combinational so a column is read before it is written.
module sobel_line_buffer
  import gray_sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 16,
  localparam int unsigned COL_W    = $clog2(IMG_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      wr_en_i,
  input  logic [COL_W-1:0]          col_i,
  input  logic [MAX_PIXEL_BITS-1:0] px_i,
  output logic [MAX_PIXEL_BITS-1:0] top_o,
  output logic [MAX_PIXEL_BITS-1:0] mid_o
);

  logic [MAX_PIXEL_BITS-1:0] line_a_mem [IMG_WIDTH];
  logic [MAX_PIXEL_BITS-1:0] line_b_mem [IMG_WIDTH];

  assign top_o = line_b_mem[col_i];
  assign mid_o = line_a_mem[col_i];

  // Contents are never cleared; the row>=2 gate upstream masks stale data.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      line_b_mem[col_i] <= line_a_mem[col_i];
      line_a_mem[col_i] <= px_i;
    end
  end

endmodule

// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 window generator for the Sobel core. Downstream backpressure
// on window_ready_i is honoured only when SOBEL_WIN_BACKPRESSURE_EN is defined.
module sobel_window_buffer
  import gray_sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned IMG_HEIGHT = 16
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  input  logic                                 px_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0]            px_i,
  output logic                                 px_ready_o,
  output logic                                 window_valid_o,
  input  logic                                 window_ready_i,
  output logic [WIN_PIXELS*MAX_PIXEL_BITS-1:0] window_o,
  output logic                                 frame_done_o
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  win_state_e                state_q, state_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d;
  win_pixels_t               win_q, win_d;
  logic                      win_valid_q, win_valid_d;
  logic                      win_ready, px_ready, accept, emit, col_last, row_last;
  logic [MAX_PIXEL_BITS-1:0] top_px, mid_px;

`ifdef SOBEL_WIN_BACKPRESSURE_EN
  assign win_ready = window_ready_i;
`else
  logic unused_window_ready;
  assign unused_window_ready = window_ready_i;
  assign win_ready           = 1'b1;
`endif

  assign px_ready = ((state_q == ST_FILL) || (state_q == ST_STREAM)) &&
                    (!win_valid_q || win_ready);
  // start_i wins over a simultaneous accept: the pixel is dropped.
  assign accept   = px_valid_i && px_ready && !start_i;
  assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign emit     = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  sobel_line_buffer #(
    .IMG_WIDTH(IMG_WIDTH)
  ) u_line_buffer (
    .clk_i  (clk_i),
    .wr_en_i(accept),
    .col_i  (col_q),
    .px_i   (px_i),
    .top_o  (top_px),
    .mid_o  (mid_px)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;

    if (win_valid_q && win_ready) win_valid_d = 1'b0;
    if (state_q == ST_DONE)       state_d     = ST_IDLE;

    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = top_px;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = mid_px;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = px_i;
      if (col_last) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (emit) begin
        win_valid_d = 1'b1;
        state_d     = ST_STREAM;
      end
      if (col_last && row_last) begin
        state_d = ST_DONE;
        row_d   = '0;
      end
    end

    if (start_i) begin
      state_d     = ST_FILL;
      row_d       = '0;
      col_d       = '0;
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign px_ready_o     = px_ready;
  assign window_valid_o = win_valid_q;
  assign window_o       = win_q;
  assign frame_done_o   = (state_q == ST_DONE);

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x4 frame with p(r,c)=8r+c.
module tb_sobel_window_buffer;
  import gray_sobel_pkg::*;

`ifdef SOBEL_WIN_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic        clk;
  logic        reset_i, start_i, px_valid_i, window_ready_i;
  logic [7:0]  px_i;
  logic        px_ready_o, window_valid_o, frame_done_o;
  logic [71:0] window_o;

  int checks = 0;
  int errors = 0;

  logic [71:0] got_win[$];
  int done_pulses, done_iter, last_acc_iter, valid_cycles, ready_drops;
  bit run_timeout;

  sobel_window_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .px_valid_i    (px_valid_i),
    .px_i          (px_i),
    .px_ready_o    (px_ready_o),
    .window_valid_o(window_valid_o),
    .window_ready_i(window_ready_i),
    .window_o      (window_o),
    .frame_done_o  (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int idx, input int off);
    return 8'(8 * (idx / 4) + (idx % 4) + off);
  endfunction

  // Window centred on (cr, cc), slot k = 3*dr + dc.
  function automatic logic [71:0] exp_win(input int cr, input int cc, input int off);
    win_pixels_t w;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[dr*3+dc] = 8'(8 * (cr - 1 + dr) + (cc - 1 + dc) + off);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Feeds pixels first_idx..n_stop-1 and records windows, frame_done and ready drops.
  task automatic run_frame(input int off, input bit toggle, input int first_idx, input int n_stop);
    int idx = first_idx;
    bit phase = 1'b1;
    int tail = 0;
    bit acc;
    done_pulses = 0; done_iter = -1; last_acc_iter = -1;
    valid_cycles = 0; ready_drops = 0; run_timeout = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (window_valid_o) begin
        valid_cycles++;
        if (window_ready_i || !BP) got_win.push_back(window_o);
      end
      if (frame_done_o) begin
        done_pulses++;
        done_iter = k;
      end
      if (idx < n_stop && !px_ready_o) ready_drops++;
      if (idx >= n_stop) begin
        if (n_stop < 16 || tail == 3) begin
          run_timeout = 1'b0;
          break;
        end
        tail++;
      end
      px_valid_i = (idx < n_stop) && (!toggle || phase);
      px_i       = pix(idx, off);
      acc        = px_valid_i && px_ready_o;
      tick();
      if (acc) begin
        idx++;
        last_acc_iter = k;
      end
      phase = !phase;
    end
    px_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; px_valid_i = 1'b0; px_i = '0; window_ready_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
    checks++; if (px_ready_o !== 1'b0) begin errors++; $display("FAIL reset_px_ready got %b exp 0", px_ready_o); end
    checks++; if (window_valid_o !== 1'b0) begin errors++; $display("FAIL reset_window_valid got %b exp 0", window_valid_o); end
    checks++; if (window_o !== 72'h0) begin errors++; $display("FAIL reset_window got %h exp 0", window_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", frame_done_o); end
  endtask

  task automatic test_continuous();
    logic [71:0] a;
    window_ready_i = 1'b1;
    pulse_start();
    got_win.delete();
    run_frame(0, 1'b0, 0, 16);
    checks++; if (run_timeout !== 1'b0) begin errors++; $display("FAIL cont_timeout got %b exp 0", run_timeout); end
    checks++; if (got_win.size() != 4) begin errors++; $display("FAIL cont_count got %0d exp 4", got_win.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < got_win.size()) ? got_win[i] : 'x;
      checks++;
      if (a !== exp_win(1 + i / 2, 1 + i % 2, 0)) begin
        errors++; $display("FAIL cont_win%0d got %h exp %h", i, a, exp_win(1 + i / 2, 1 + i % 2, 0));
      end
    end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL cont_done_pulses got %0d exp 1", done_pulses); end
    checks++; if (done_iter != last_acc_iter + 1) begin errors++; $display("FAIL cont_done_timing got %0d exp %0d", done_iter, last_acc_iter + 1); end
    checks++; if (valid_cycles != 4) begin errors++; $display("FAIL cont_valid_cycles got %0d exp 4", valid_cycles); end
    checks++; if (ready_drops != 0) begin errors++; $display("FAIL cont_ready_drops got %0d exp 0", ready_drops); end
    checks++; if (px_ready_o !== 1'b0) begin errors++; $display("FAIL cont_idle_ready got %b exp 0", px_ready_o); end
  endtask

`ifdef SOBEL_WIN_BACKPRESSURE_EN
  task automatic test_backpressure();
    logic [71:0] a;
    int idx = 0;
    bit acc;
    window_ready_i = 1'b1;
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      if (window_valid_o) break;
      px_valid_i = 1'b1;
      px_i       = pix(idx, 0);
      acc        = px_ready_o;
      tick();
      if (acc) idx++;
    end
    checks++; if (window_valid_o !== 1'b1) begin errors++; $display("FAIL bp_first_valid got %b exp 1", window_valid_o); end
    checks++; if (idx != 11) begin errors++; $display("FAIL bp_first_latency got %0d exp 11", idx); end
    window_ready_i = 1'b0;
    px_valid_i     = 1'b1;
    px_i           = pix(idx, 0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (px_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold_ready%0d got %b exp 0", k, px_ready_o); end
      checks++; if (window_valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d got %b exp 1", k, window_valid_o); end
      checks++; if (window_o !== exp_win(1, 1, 0)) begin errors++; $display("FAIL bp_hold_win%0d got %h exp %h", k, window_o, exp_win(1, 1, 0)); end
      tick();
    end
    window_ready_i = 1'b1;
    got_win.delete();
    run_frame(0, 1'b0, idx, 16);
    checks++; if (run_timeout !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", run_timeout); end
    checks++; if (got_win.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got_win.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < got_win.size()) ? got_win[i] : 'x;
      checks++;
      if (a !== exp_win(1 + i / 2, 1 + i % 2, 0)) begin
        errors++; $display("FAIL bp_win%0d got %h exp %h", i, a, exp_win(1 + i / 2, 1 + i % 2, 0));
      end
    end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL bp_done_pulses got %0d exp 1", done_pulses); end
  endtask
`else
  task automatic test_no_backpressure();
    logic [71:0] a;
    window_ready_i = 1'b0;
    pulse_start();
    got_win.delete();
    run_frame(0, 1'b0, 0, 16);
    checks++; if (run_timeout !== 1'b0) begin errors++; $display("FAIL nobp_timeout got %b exp 0", run_timeout); end
    checks++; if (got_win.size() != 4) begin errors++; $display("FAIL nobp_count got %0d exp 4", got_win.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < got_win.size()) ? got_win[i] : 'x;
      checks++;
      if (a !== exp_win(1 + i / 2, 1 + i % 2, 0)) begin
        errors++; $display("FAIL nobp_win%0d got %h exp %h", i, a, exp_win(1 + i / 2, 1 + i % 2, 0));
      end
    end
    checks++; if (valid_cycles != 4) begin errors++; $display("FAIL nobp_valid_cycles got %0d exp 4", valid_cycles); end
    checks++; if (ready_drops != 0) begin errors++; $display("FAIL nobp_ready_drops got %0d exp 0", ready_drops); end
    checks++; if (done_pulses != 1) begin errors++; $display("FAIL nobp_done_pulses got %0d exp 1", done_pulses); end
    window_ready_i = 1'b1;
  endtask
`endif

  task automatic test_restart();
    logic [71:0] a;
    window_ready_i = 1'b1;
    pulse_start();
    run_frame(0, 1'b0, 0, 9);
    px_valid_i = 1'b1;
    px_i       = pix(9, 0);
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
    px_valid_i = 1'b0;
    checks++; if (window_valid_o !== 1'b0) begin errors++; $display("FAIL restart_valid got %b exp 0", window_valid_o); end
    checks++; if (px_ready_o !== 1'b1) begin errors++; $display("FAIL restart_ready got %b exp 1", px_ready_o); end
    got_win.delete();
    run_frame(100, 1'b0, 0, 16);
    checks++; if (got_win.size() != 4) begin errors++; $display("FAIL restart_count got %0d exp 4", got_win.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < got_win.size()) ? got_win[i] : 'x;
      checks++;
      if (a !== exp_win(1 + i / 2, 1 + i % 2, 100)) begin
        errors++; $display("FAIL restart_win%0d got %h exp %h", i, a, exp_win(1 + i / 2, 1 + i % 2, 100));
      end
    end
  endtask

  task automatic test_reset_mid();
    window_ready_i = 1'b1;
    pulse_start();
    run_frame(0, 1'b0, 0, 12);
    checks++; if (window_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pending got %b exp 1", window_valid_o); end
    reset_i    = 1'b1;
    px_valid_i = 1'b1;
    px_i       = pix(12, 0);
    tick();
    reset_i = 1'b0;
    checks++; if (px_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b exp 0", px_ready_o); end
    checks++; if (window_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", window_valid_o); end
    checks++; if (window_o !== 72'h0) begin errors++; $display("FAIL rmid_window got %h exp 0", window_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", frame_done_o); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (px_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_idle_ready%0d got %b exp 0", k, px_ready_o); end
    end
    px_valid_i = 1'b0;
    pulse_start();
    checks++; if (px_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_start_ready got %b exp 1", px_ready_o); end
  endtask

  task automatic test_toggle();
    logic [71:0] a;
    window_ready_i = 1'b1;
    pulse_start();
    got_win.delete();
    run_frame(0, 1'b1, 0, 16);
    checks++; if (run_timeout !== 1'b0) begin errors++; $display("FAIL toggle_timeout got %b exp 0", run_timeout); end
    checks++; if (got_win.size() != 4) begin errors++; $display("FAIL toggle_count got %0d exp 4", got_win.size()); end
    for (int i = 0; i < 4; i++) begin
      a = (i < got_win.size()) ? got_win[i] : 'x;
      checks++;
      if (a !== exp_win(1 + i / 2, 1 + i % 2, 0)) begin
        errors++; $display("FAIL toggle_win%0d got %h exp %h", i, a, exp_win(1 + i / 2, 1 + i % 2, 0));
      end
    end
    checks++; if (done_iter != last_acc_iter + 1) begin errors++; $display("FAIL toggle_done_timing got %0d exp %0d", done_iter, last_acc_iter + 1); end
  endtask

  initial begin
    test_reset();
    test_continuous();
`ifdef SOBEL_WIN_BACKPRESSURE_EN
    test_backpressure();
`else
    test_no_backpressure();
`endif
    test_restart();
    test_reset_mid();
    test_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_buffer.md
# sobel_window_buffer

Streaming 3x3 window generator between the SPI pixel deserializer and the Sobel core. It takes a raster-order stream of grayscale pixels, keeps the last two image lines in on-chip line buffers, and emits one 3x3 neighbourhood per interior pixel. The Sobel core computes its gradient directly from each window.

## Interface
Parameters:
- MAX_PIXEL_BITS, 8, pixel width (from shared package)
- IMG_WIDTH, 16, pixels per line, minimum 3
- IMG_HEIGHT, 16, lines per frame, minimum 3

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  reset; synchronous, active-high
- start_i  in  1  frame start; clears counters and enters FILL
- px_valid_i  in  1  input pixel valid
- px_i  in  MAX_PIXEL_BITS  input gray pixel, raster order
- px_ready_o  out  1  pixel accepted when px_valid_i && px_ready_o
- window_valid_o  out  1  window_o holds a valid window
- window_ready_i  in  1  downstream accepts the window
- window_o  out  9*MAX_PIXEL_BITS  row-major 3x3 window
  - slot k occupies bits [k*MAX_PIXEL_BITS +: MAX_PIXEL_BITS]
  - k=0 is top-left, k=8 is bottom-right
- frame_done_o  out  1  one-cycle pulse after the last frame pixel is accepted

## Operation
- States: IDLE, FILL, STREAM, DONE.
  - IDLE --start_i--> FILL.
  - FILL --accept with row>=2 && col>=2 next--> STREAM. STREAM is entered when the next accepted pixel completes a full window.
  - FILL/STREAM --accept at row=IMG_HEIGHT-1, col=IMG_WIDTH-1--> DONE.
  - DONE --> IDLE unconditionally. frame_done_o is high during the DONE cycle.
  - start_i in any state --> FILL, with row=col=0.
- px_ready_o = (state is FILL or STREAM) && (!window_valid_o || window_ready_i). It is 0 in IDLE and DONE.
- On each accept, pixel (row, col):
  - new column = {lineB[col], lineA[col], px_i}, ordered top to bottom.
  - The window shifts left by one column and the new column enters on the right.
  - lineB[col] <= lineA[col]; lineA[col] <= px_i.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
- A window is emitted only if the accepted pixel has row>=2 && col>=2.
  - It is centred on (row-1, col-1).
  - A frame produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
  - No windows are produced at the borders. Stale columns left over from the previous line are never emitted because of the col>=2 gate.
- Counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). Pixels are stored unmodified, with no arithmetic.
- Line buffer contents are not cleared by reset_i or start_i. The row>=2 gate masks them.

## Timing
- Reset values: state IDLE, row=col=0, px_ready_o=0, window_valid_o=0, window_o=0, frame_done_o=0.
- Latency: a pixel accepted in cycle N that completes a window gives window_valid_o=1 with that window in cycle N+1.
- Handshake:
  - While window_valid_o && !window_ready_i, window_o is held stable and px_ready_o=0.
  - window_valid_o falls the cycle after a transfer unless a new window is produced in the same cycle.
- Throughput: one pixel per cycle when window_ready_i is held high.
- start_i with a simultaneous accept: start_i wins, the pixel is dropped, and window_valid_o is cleared next cycle.
- The last pixel is accepted in cycle N:
  - the final window is valid in N+1;
  - frame_done_o=1 in N+1;
  - the final window transfers independently of the return to IDLE.
- reset_i mid-frame: all outputs return to their reset values on the next edge, and any pending window is discarded.

## Configuration
- SOBEL_WIN_BACKPRESSURE_EN defined: window_ready_i is honoured as described above.
- Macro undefined:
  - window_ready_i is ignored and treated as 1.
  - px_ready_o = state is FILL or STREAM.
  - windows are valid for exactly one cycle.

## Structure
- Shared package gray_sobel_pkg holds:
  - MAX_PIXEL_BITS;
  - WIN_PIXELS=9;
  - the window state enum typedef;
  - the window pixel-array typedef.
- One sub-module, sobel_line_buffer, holds the two IMG_WIDTH-deep lines, with a read-then-write per column on accept.
- Window registers, counters and the FSM stay in sobel_window_buffer.

## Test plan
Bench settings: IMG_WIDTH=4, IMG_HEIGHT=4, pixel p(r,c)=8r+c, window_ready_i=1 unless stated otherwise.
- Full frame, continuous stream: exactly 4 windows. The first is {0,1,2,8,9,10,16,17,18}, the last is {9,10,11,17,18,19,25,26,27}. frame_done_o pulses once, one cycle after pixel 27 is accepted.
- window_ready_i held low for 5 cycles after the first window: window_o stays stable and px_ready_o=0 for all 5 cycles. The full frame still yields 4 correct windows (macro defined).
- start_i asserted mid-frame at row 2, col 1, then a fresh frame of p(r,c)+100: the windows contain only new-frame values, the first being {100,101,102,108,...}.
- reset_i pulsed at row 3: all outputs are 0 next cycle and state is IDLE; px_ready_o stays 0 until start_i.
- px_valid_i toggling 1/0 each cycle: same 4 windows, same values as the continuous case.
- Macro undefined, window_ready_i=0 throughout: 4 single-cycle windows with correct values; px_ready_o never deasserts in FILL or STREAM.
